vram_cpu_port: RTL



---
 rtl/vram_cpu_port.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: m6502 bus access to font/attr/cell video RAM (port A) plus a block-fill engine.
module vram_cpu_port #(
    parameter logic [15:0] REG_BASE = 16'h6F00,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic        cpu_clk,
    input  logic        act_reset,
    input  logic        cpu_cs,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dataw,
    output logic        cpu_memrdy,
    output logic        cpu_datavalid,
    output logic [7:0]  cpu_datar,
    output logic [13:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        font_we,
    output logic        attr_we,
    output logic        cell_we,
    input  logic [7:0]  font_rdata,
    input  logic [7:0]  attr_rdata,
    input  logic [7:0]  cell_rdata,
    output logic        fill_busy
);

    localparam int unsigned AW  = 16;
    localparam int unsigned RAW = 14;
    localparam int unsigned DW  = 8;
    localparam int unsigned WW  = 4;

    typedef enum logic [2:0] {RGN_NONE, RGN_FONT, RGN_ATTR, RGN_CELL, RGN_REG} region_t;
    typedef enum logic [1:0] {RD_IDLE, RD_1, RD_2} rd_state_t;
    typedef enum logic       {FILL_IDLE, FILL_RUN} fill_state_t;

    // Region decode from address bits [15:3]; the register window is checked first.
    function automatic region_t decode(input logic [AW-4:0] hi);
        region_t r;
        if (hi == REG_BASE[AW-1:3])         r = RGN_REG;
        else if (hi[AW-4:AW-5] == 2'b11)    r = RGN_CELL;
        else if (hi[AW-4:AW-5] == 2'b10)    r = RGN_ATTR;
        else if (hi[AW-4:AW-7] == 4'h7)     r = RGN_FONT;
        else                                r = RGN_NONE;
        return r;
    endfunction

    // Port-A word address: font is 4 KiB, attr and cell are 16 KiB.
    function automatic logic [RAW-1:0] ram_index(input region_t r, input logic [RAW-1:0] a);
        return (r == RGN_FONT) ? {2'b00, a[11:0]} : a;
    endfunction

    rd_state_t          r_rd_state;
    region_t            r_rd_src;
    logic [DW-1:0]      r_rd_reg;
    logic [WW-1:0]      r_rd_wait;

    fill_state_t        r_fill_state;
    logic [AW-1:0]      r_fill_addr;
    logic [AW-1:0]      r_fill_cnt;
    logic [DW-1:0]      r_fill_value;
    logic               r_done;
    logic [AW-1:0]      r_cur_addr;
    logic [AW-1:0]      r_cur_cnt;

    region_t            w_cpu_rgn;
    region_t            w_fill_rgn;
    logic               w_cpu_is_ram;
    logic               w_fill_is_ram;
    logic               w_accept;
    logic               w_reg_wr;
    logic               w_start;
    logic [DW-1:0]      w_reg_rdata;
    logic [DW-1:0]      w_rd_mux;

    assign w_cpu_rgn     = decode(cpu_addr[AW-1:3]);
    assign w_fill_rgn    = decode(r_cur_addr[AW-1:3]);
    assign w_cpu_is_ram  = (w_cpu_rgn == RGN_FONT) || (w_cpu_rgn == RGN_ATTR) || (w_cpu_rgn == RGN_CELL);
    assign w_fill_is_ram = (w_fill_rgn == RGN_FONT) || (w_fill_rgn == RGN_ATTR) || (w_fill_rgn == RGN_CELL);

    assign fill_busy  = (r_fill_state == FILL_RUN);
    assign cpu_memrdy = (r_rd_state == RD_IDLE) && !(fill_busy && w_cpu_is_ram);
    assign w_accept   = cpu_cs && cpu_memrdy;
    assign w_reg_wr   = w_accept && cpu_wr && (w_cpu_rgn == RGN_REG);
    assign w_start    = w_reg_wr && (cpu_addr[2:0] == 3'd5) && cpu_dataw[0] && !fill_busy;

    // Register-window read value, captured when a register read is accepted.
    always_comb begin
        w_reg_rdata = '0;
        case (cpu_addr[2:0])
            3'd0:    w_reg_rdata = r_fill_addr[7:0];
            3'd1:    w_reg_rdata = r_fill_addr[15:8];
            3'd2:    w_reg_rdata = r_fill_cnt[7:0];
            3'd3:    w_reg_rdata = r_fill_cnt[15:8];
            3'd4:    w_reg_rdata = r_fill_value;
            3'd5:    w_reg_rdata = {fill_busy, 6'b0, r_done};
            default: w_reg_rdata = '0;
        endcase
    end

    // Read-data select at the end of RD2; unmapped reads return all ones.
    always_comb begin
        w_rd_mux = 8'hFF;
        case (r_rd_src)
            RGN_FONT: w_rd_mux = font_rdata;
            RGN_ATTR: w_rd_mux = attr_rdata;
            RGN_CELL: w_rd_mux = cell_rdata;
            RGN_REG:  w_rd_mux = r_rd_reg;
            default:  w_rd_mux = 8'hFF;
        endcase
    end

    // CPU read sequencer: address out, RAM sync read, then output register with datavalid strobe.
    always_ff @(posedge cpu_clk or posedge act_reset) begin
        if (act_reset) begin
            r_rd_state    <= RD_IDLE;
            r_rd_src      <= RGN_NONE;
            r_rd_reg      <= '0;
            r_rd_wait     <= '0;
            cpu_datavalid <= 1'b0;
            cpu_datar     <= '0;
        end else begin
            cpu_datavalid <= 1'b0;
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_accept && !cpu_wr) begin
                        r_rd_state <= RD_1;
                        r_rd_src   <= w_cpu_rgn;
                        r_rd_reg   <= w_reg_rdata;
                        r_rd_wait  <= WW'(RD_LAT - 2);
                    end
                end
                RD_1: begin
                    if (r_rd_wait == '0) r_rd_state <= RD_2;
                    else                 r_rd_wait  <= r_rd_wait - 4'd1;
                end
                RD_2: begin
                    r_rd_state    <= RD_IDLE;
                    cpu_datavalid <= 1'b1;
                    cpu_datar     <= w_rd_mux;
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    // Port-A driver: the fill engine owns the port while busy, otherwise CPU RAM accesses.
    always_ff @(posedge cpu_clk or posedge act_reset) begin
        if (act_reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            font_we   <= 1'b0;
            attr_we   <= 1'b0;
            cell_we   <= 1'b0;
        end else begin
            font_we <= 1'b0;
            attr_we <= 1'b0;
            cell_we <= 1'b0;
            if (fill_busy) begin
                if (w_fill_is_ram) begin
                    ram_addr  <= ram_index(w_fill_rgn, r_cur_addr[RAW-1:0]);
                    ram_wdata <= r_fill_value;
                    font_we   <= (w_fill_rgn == RGN_FONT);
                    attr_we   <= (w_fill_rgn == RGN_ATTR);
                    cell_we   <= (w_fill_rgn == RGN_CELL);
                end
            end else if (w_accept && w_cpu_is_ram) begin
                ram_addr <= ram_index(w_cpu_rgn, cpu_addr[RAW-1:0]);
                if (cpu_wr) begin
                    ram_wdata <= cpu_dataw;
                    font_we   <= (w_cpu_rgn == RGN_FONT);
                    attr_we   <= (w_cpu_rgn == RGN_ATTR);
                    cell_we   <= (w_cpu_rgn == RGN_CELL);
                end
            end
        end
    end

    // Fill registers and fill engine: one byte per cycle, sticky done flag.
    always_ff @(posedge cpu_clk or posedge act_reset) begin
        if (act_reset) begin
            r_fill_state <= FILL_IDLE;
            r_fill_addr  <= '0;
            r_fill_cnt   <= '0;
            r_fill_value <= '0;
            r_done       <= 1'b0;
            r_cur_addr   <= '0;
            r_cur_cnt    <= '0;
        end else begin
            if (w_reg_wr && !fill_busy) begin
                case (cpu_addr[2:0])
                    3'd0:    r_fill_addr[7:0]  <= cpu_dataw;
                    3'd1:    r_fill_addr[15:8] <= cpu_dataw;
                    3'd2:    r_fill_cnt[7:0]   <= cpu_dataw;
                    3'd3:    r_fill_cnt[15:8]  <= cpu_dataw;
                    3'd4:    r_fill_value      <= cpu_dataw;
                    default: ;
                endcase
            end
            case (r_fill_state)
                FILL_IDLE: begin
                    if (w_start) begin
                        if (r_fill_cnt == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_fill_state <= FILL_RUN;
                            r_done       <= 1'b0;
                            r_cur_addr   <= r_fill_addr;
                            r_cur_cnt    <= r_fill_cnt;
                        end
                    end
                end
                FILL_RUN: begin
                    r_cur_addr <= r_cur_addr + 16'd1;
                    r_cur_cnt  <= r_cur_cnt - 16'd1;
                    if (r_cur_cnt == 16'd1) begin
                        r_fill_state <= FILL_IDLE;
                        r_done       <= 1'b1;
                    end
                end
                default: r_fill_state <= FILL_IDLE;
            endcase
        end
    end

endmodule
